// File: rtl/swap_mutator_n_if.sv
// Handshake/data bundle between a mutation requester and swap_mutator_n.
// master drives start/mode/prg_seed/parent; slave returns mutant/busy/done/skipped.
interface swap_mutator_n_if #(
    parameter int GENE_W = 5,
    parameter int GENE_N = 15,
    parameter int CNT_W  = 2
);
    logic                     start;
    logic                     mode;
    logic [31:0]              prg_seed;
    logic [GENE_W*GENE_N-1:0] parent;
    logic [GENE_W*GENE_N-1:0] mutant;
    logic                     busy;
    logic                     done;
    logic [CNT_W:0]           skipped;

    modport master (
        output start,
        output mode,
        output prg_seed,
        output parent,
        input  mutant,
        input  busy,
        input  done,
        input  skipped
    );

    modport slave (
        input  start,
        input  mode,
        input  prg_seed,
        input  parent,
        output mutant,
        output busy,
        output done,
        output skipped
    );
endinterface

// File: rtl/swap_mutator_n.sv
// Genome mutator: per run, swaps gene pairs (mode 0) or overwrites genes
// with random values (mode 1), using a 32-bit Galois LFSR for all draws.
// Ports: clk, rst (sync, active high), bus (slave side of swap_mutator_n_if):
//   start/mode/prg_seed/parent in; mutant/busy/done/skipped out.
module swap_mutator_n #(
    parameter int GENE_W    = 5,
    parameter int GENE_N    = 15,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 2,
    parameter int MAX_RETRY = 15
) (
    input  logic               clk,
    input  logic               rst,
    swap_mutator_n_if.slave    bus
);

    localparam int GW    = GENE_W * GENE_N;
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
    localparam logic [IDX_W:0]   GN_LIM    = (IDX_W + 1)'(GENE_N);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE   = RTY_W'(1);
    localparam logic [CNT_W:0]   OPS_ONE   = (CNT_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COUNT,
        DRAW,
        APPLY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     mutant_q, mutant_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic              mode_q, mode_d;
    logic [CNT_W:0]    ops_q, ops_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [CNT_W:0]    skipped_q, skipped_d;
    logic [IDX_W-1:0]  i0_q, i0_d;
    logic [IDX_W-1:0]  i1_q, i1_d;
    logic [GENE_W-1:0] v_q, v_d;

    logic [31:0]       lfsr_step;
    logic [IDX_W-1:0]  draw_i0;
    logic [IDX_W-1:0]  draw_i1;
    logic [GENE_W-1:0] draw_v;
    logic              i0_ok;
    logic              i1_ok;
    logic              draw_ok;
    logic              last_op;
    logic              finish;
    logic [GENE_W-1:0] gene_a;
    logic [GENE_W-1:0] gene_b;

    assign lfsr_step = {1'b0, lfsr_q[31:1]}
                     ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);

    assign draw_i0 = lfsr_q[IDX_W-1:0];
    assign draw_i1 = lfsr_q[IDX_W+15:16];

    // Random value comes from the top byte; wide genes are zero-extended.
    generate
        if (GENE_W >= 8) begin : g_v_wide
            assign draw_v = GENE_W'(lfsr_q[31:24]);
        end else begin : g_v_narrow
            assign draw_v = lfsr_q[GENE_W+23:24];
        end
    endgenerate

    assign i0_ok   = {1'b0, draw_i0} < GN_LIM;
    assign i1_ok   = ({1'b0, draw_i1} < GN_LIM)
                   && (draw_i1 != draw_i0);
    // Overwrite mode only needs one index; i1 is don't-care there.
    assign draw_ok = i0_ok && (mode_q || i1_ok);
    assign last_op = (ops_q == OPS_ONE);

    // Gene read muxes for the swap; loop keeps indices in range.
    always_comb begin
        gene_a = '0;
        gene_b = '0;
        for (int g = 0; g < GENE_N; g++) begin
            if (IDX_W'(g) == i0_q) begin
                gene_a = mutant_q[GENE_W*g +: GENE_W];
            end
            if (IDX_W'(g) == i1_q) begin
                gene_b = mutant_q[GENE_W*g +: GENE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mutant_d  = mutant_q;
        lfsr_d    = lfsr_q;
        mode_d    = mode_q;
        ops_d     = ops_q;
        retry_d   = retry_q;
        skipped_d = skipped_q;
        i0_d      = i0_q;
        i1_d      = i1_q;
        v_d       = v_q;
        finish    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mutant_d  = bus.parent;
                    mode_d    = bus.mode;
                    // All-zero LFSR would lock up; remap it.
                    lfsr_d    = (bus.prg_seed == 32'h0)
                              ? 32'h1 : bus.prg_seed;
                    skipped_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                lfsr_d  = lfsr_step;
                state_d = COUNT;
            end
            COUNT: begin
                ops_d   = {1'b0, lfsr_q[CNT_W+7:8]} + OPS_ONE;
                retry_d = '0;
                lfsr_d  = lfsr_step;
                state_d = DRAW;
            end
            DRAW: begin
                if (draw_ok) begin
                    i0_d    = draw_i0;
                    i1_d    = draw_i1;
                    v_d     = draw_v;
                    state_d = APPLY;
                end else if (retry_q < RTY_MAX) begin
                    lfsr_d  = lfsr_step;
                    retry_d = retry_q + RTY_ONE;
                end else begin
                    skipped_d = skipped_q + OPS_ONE;
                    finish    = 1'b1;
                end
            end
            APPLY: begin
                for (int g = 0; g < GENE_N; g++) begin
                    if (IDX_W'(g) == i0_q) begin
                        mutant_d[GENE_W*g +: GENE_W] =
                            mode_q ? v_q : gene_b;
                    end
                    if (!mode_q && (IDX_W'(g) == i1_q)) begin
                        mutant_d[GENE_W*g +: GENE_W] = gene_a;
                    end
                end
                finish = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared tail for applied and abandoned operations alike.
        if (finish) begin
            ops_d   = ops_q - OPS_ONE;
            retry_d = '0;
            lfsr_d  = lfsr_step;
            state_d = last_op ? DONE : DRAW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mutant_q  <= '0;
            lfsr_q    <= 32'h1;
            mode_q    <= 1'b0;
            ops_q     <= '0;
            retry_q   <= '0;
            skipped_q <= '0;
            i0_q      <= '0;
            i1_q      <= '0;
            v_q       <= '0;
        end else begin
            state_q   <= state_d;
            mutant_q  <= mutant_d;
            lfsr_q    <= lfsr_d;
            mode_q    <= mode_d;
            ops_q     <= ops_d;
            retry_q   <= retry_d;
            skipped_q <= skipped_d;
            i0_q      <= i0_d;
            i1_q      <= i1_d;
            v_q       <= v_d;
        end
    end

    assign bus.mutant  = mutant_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.skipped = skipped_q;

endmodule

// File: tb/tb_swap_mutator_n.sv
// Scoreboard bench for swap_mutator_n: a 15-gene instance and a 1-gene
// instance, each with an expected-result queue popped on every done pulse.
module tb_swap_mutator_n;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [79:0] mut;
        int          skp;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n0 = 0;
    int   n1 = 0;
    int   cnt0 = 0;
    int   cnt1 = 0;
    bit   pd0 = 0;
    bit   pd1 = 0;

    swap_mutator_n_if #(.GENE_W(5), .GENE_N(15), .CNT_W(2)) bus0 ();
    swap_mutator_n_if #(.GENE_W(5), .GENE_N(1), .CNT_W(2)) bus1 ();

    swap_mutator_n #(
        .GENE_W(5), .GENE_N(15), .IDX_W(4),
        .CNT_W(2), .MAX_RETRY(15)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    swap_mutator_n #(
        .GENE_W(5), .GENE_N(1), .IDX_W(4),
        .CNT_W(2), .MAX_RETRY(15)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name,
                       input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Algorithmic reference: returns final genome, skip count,
    // number of busy cycles (including DONE) and op count.
    task automatic ref_run(input logic [79:0] par,
                           input bit md,
                           input logic [31:0] seed,
                           input int gn,
                           output logic [79:0] mut,
                           output int skp,
                           output int cyc,
                           output int ops);
        logic [31:0] l;
        logic [4:0]  ga;
        logic [4:0]  gb;
        int          r;
        int          i0;
        int          i1;
        bit          ok;
        bit          fin;
        mut = par;
        skp = 0;
        l   = (seed == 32'h0) ? 32'h1 : seed;
        l   = step(l);
        ops = int'(l[9:8]) + 1;
        l   = step(l);
        cyc = 2;
        for (int k = 0; k < ops; k++) begin
            r   = 0;
            fin = 0;
            while (!fin) begin
                cyc++;
                i0 = int'(l[3:0]);
                i1 = int'(l[19:16]);
                ok = (i0 < gn) && (md || ((i1 < gn) && (i1 != i0)));
                if (ok) begin
                    cyc++;
                    if (md) begin
                        mut[5*i0 +: 5] = l[28:24];
                    end else begin
                        ga = mut[5*i0 +: 5];
                        gb = mut[5*i1 +: 5];
                        mut[5*i0 +: 5] = gb;
                        mut[5*i1 +: 5] = ga;
                    end
                    l   = step(l);
                    fin = 1;
                end else if (r < 15) begin
                    l = step(l);
                    r++;
                end else begin
                    skp++;
                    l   = step(l);
                    fin = 1;
                end
            end
        end
        cyc++;
    endtask

    // Monitor for the 15-gene instance.
    always @(negedge clk) begin
        exp_t e;
        if (!bus0.busy) cnt0 = 0;
        else cnt0++;
        if (bus0.done) begin
            chk("dut0_done_width", {79'b0, pd0}, 80'd0);
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_done: got done expected none");
            end else begin
                e = q0.pop_front();
                chk("dut0_mutant", {5'b0, bus0.mutant}, e.mut);
                chk("dut0_skipped", 80'(bus0.skipped), 80'(e.skp));
                chk("dut0_latency", 80'(cnt0), 80'(e.cyc));
            end
            n0++;
        end
        pd0 = bus0.done;
    end

    // Monitor for the 1-gene instance.
    always @(negedge clk) begin
        exp_t e;
        if (!bus1.busy) cnt1 = 0;
        else cnt1++;
        if (bus1.done) begin
            chk("dut1_done_width", {79'b0, pd1}, 80'd0);
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_done: got done expected none");
            end else begin
                e = q1.pop_front();
                chk("dut1_mutant", {75'b0, bus1.mutant}, e.mut);
                chk("dut1_skipped", 80'(bus1.skipped), 80'(e.skp));
                chk("dut1_latency", 80'(cnt1), 80'(e.cyc));
            end
            n1++;
        end
        pd1 = bus1.done;
    end

    task automatic wait_n0(input int target);
        int k;
        k = 0;
        while (n0 < target && k < 600) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (n0 < target) begin
            errors++;
            $display("FAIL dut0_wait_done: got %0d done expected %0d",
                     n0, target);
        end
    endtask

    task automatic wait_n1(input int target);
        int k;
        k = 0;
        while (n1 < target && k < 600) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (n1 < target) begin
            errors++;
            $display("FAIL dut1_wait_done: got %0d done expected %0d",
                     n1, target);
        end
    endtask

    task automatic run0(input logic [74:0] par,
                        input bit md,
                        input logic [31:0] seed,
                        output logic [79:0] m,
                        output int ops);
        exp_t e;
        int   t;
        ref_run({5'b0, par}, md, seed, 15, e.mut, e.skp, e.cyc, ops);
        m = e.mut;
        q0.push_back(e);
        t = n0 + 1;
        @(negedge clk);
        bus0.parent   = par;
        bus0.mode     = md;
        bus0.prg_seed = seed;
        bus0.start    = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_n0(t);
    endtask

    task automatic run1(input logic [4:0] par,
                        input bit md,
                        input logic [31:0] seed,
                        output int ops);
        exp_t e;
        int   t;
        ref_run({75'b0, par}, md, seed, 1, e.mut, e.skp, e.cyc, ops);
        q1.push_back(e);
        t = n1 + 1;
        @(negedge clk);
        bus1.parent   = par;
        bus1.mode     = md;
        bus1.prg_seed = seed;
        bus1.start    = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_n1(t);
    endtask

    initial begin
        logic [74:0] par;
        logic [79:0] m;
        int          ops;
        int          hist;
        int          nz;

        // Reset held two cycles with start high: nothing may launch.
        rst           = 1'b1;
        bus0.start    = 1'b1;
        bus0.mode     = 1'b0;
        bus0.prg_seed = 32'h1234_5678;
        bus0.parent   = '1;
        bus1.start    = 1'b1;
        bus1.mode     = 1'b0;
        bus1.prg_seed = 32'h1;
        bus1.parent   = 5'h1B;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mutant", {5'b0, bus0.mutant}, 80'd0);
        chk("rst_busy", {79'b0, bus0.busy}, 80'd0);
        chk("rst_done", {79'b0, bus0.done}, 80'd0);
        chk("rst_skipped", 80'(bus0.skipped), 80'd0);
        chk("rst1_mutant", {75'b0, bus1.mutant}, 80'd0);
        rst        = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {79'b0, bus0.busy}, 80'd0);

        // Identity genome, swap mode.
        for (int g = 0; g < 15; g++) par[5*g +: 5] = 5'(g);
        run0(par, 1'b0, 32'hDEAD_BEEF, m, ops);
        hist = 0;
        for (int v = 0; v < 15; v++) begin
            int c;
            c = 0;
            for (int g = 0; g < 15; g++)
                if (bus0.mutant[5*g +: 5] == 5'(v)) c++;
            if (c == 1) hist++;
        end
        chk("perm_distinct", 80'(hist), 80'd15);

        // Reversed genome, swap mode.
        for (int g = 0; g < 15; g++) par[5*g +: 5] = 5'(31 - g);
        run0(par, 1'b0, 32'hA5A5_0001, m, ops);

        // Zero seed must behave exactly like seed 1.
        for (int g = 0; g < 15; g++) par[5*g +: 5] = 5'((3 * g) % 32);
        run0(par, 1'b0, 32'h0, m, ops);
        run0(par, 1'b0, 32'h1, m, ops);

        // Overwrite mode on a non-trivial genome.
        run0(par, 1'b1, 32'hCAFE_F00D, m, ops);

        // Overwrite mode on all-zero genome, then hold in IDLE.
        run0('0, 1'b1, 32'h1234_5678, m, ops);
        nz = 0;
        for (int g = 0; g < 15; g++)
            if (bus0.mutant[5*g +: 5] != 5'd0) nz++;
        checks++;
        if (nz > ops) begin
            errors++;
            $display("FAIL ovw_nonzero: got %0d genes expected <= %0d",
                     nz, ops);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_hold", {5'b0, bus0.mutant}, m);
        end

        // Single-gene genome: every swap op must be skipped.
        run1(5'h1B, 1'b0, 32'h0BAD_F00D, ops);
        chk("g1_skip_eq_ops", 80'(bus1.skipped), 80'(ops));
        run1(5'h1B, 1'b0, 32'h7777_0003, ops);
        chk("g1_skip_eq_ops2", 80'(bus1.skipped), 80'(ops));

        // Second start mid-run is ignored; reset abandons the run.
        @(negedge clk);
        bus0.parent   = par;
        bus0.mode     = 1'b0;
        bus0.prg_seed = 32'h0F0F_0F0F;
        bus0.start    = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        chk("abort_started", {79'b0, bus0.busy}, 80'd1);
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mutant", {5'b0, bus0.mutant}, 80'd0);
        chk("abort_busy", {79'b0, bus0.busy}, 80'd0);
        repeat (60) @(negedge clk);
        chk("abort_idle", {79'b0, bus0.busy}, 80'd0);
        chk("abort_no_done", 80'(n0), 80'd6);

        repeat (2) @(negedge clk);
        chk("sb0_empty", 80'(q0.size()), 80'd0);
        chk("sb1_empty", 80'(q1.size()), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/swap_mutator_n.md
SWAP_MUTATOR_N -- requirements
Module: swap_mutator_n

Interface
REQ-001 SHALL have parameter GENE_W, default 5: bits per gene.
REQ-002 SHALL have parameter GENE_N, default 15: genes per genome; legal range 1..2^IDX_W.
REQ-003 SHALL have parameter IDX_W, default 4: gene index width.
REQ-004 SHALL have parameter CNT_W, default 2: operation-count width; ops per run are 1..2^CNT_W.
REQ-005 SHALL have parameter MAX_RETRY, default 15: index draws allowed per operation before that operation is skipped.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: request one mutation run.
REQ-009 SHALL have port mode, input, 1: 0 = swap two genes; 1 = overwrite one gene with a random value.
REQ-010 SHALL have port prg_seed, input, 32: LFSR seed.
REQ-011 SHALL have port parent, input, GENE_W*GENE_N: source genome; gene g occupies bits [GENE_W*g +: GENE_W].
REQ-012 SHALL have port mutant, output reg, GENE_W*GENE_N: working and result genome.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse in state DONE.
REQ-015 SHALL have port skipped, output reg, CNT_W+1: count of operations abandoned at MAX_RETRY during the last run.

Function
REQ-016 SHALL contain an internal 32-bit Galois LFSR "lfsr" shifting right, XOR mask 32'h80200003 applied when the shifted-out bit is 1; "step" means one such advance.
REQ-017 SHALL use states IDLE, LOAD, COUNT, DRAW, APPLY, DONE.
REQ-018 In IDLE with start=1, SHALL on the next edge load mutant<=parent, latch mode, set lfsr<=prg_seed (32'h1 if prg_seed==0), clear skipped, and go to LOAD; start SHALL be ignored in every other state.
REQ-019 In LOAD, SHALL step lfsr and go to COUNT.
REQ-020 In COUNT, SHALL set ops_left<=lfsr[CNT_W+7:8]+1 (width CNT_W+1, no wrap), clear retry, step lfsr, and go to DRAW.
REQ-021 In DRAW, SHALL take i0=lfsr[IDX_W-1:0] and i1=lfsr[IDX_W+15:16].
REQ-022 Draw is valid when i0<GENE_N and, in mode 0, i1<GENE_N and i1!=i0; in mode 1, i1 is ignored.
REQ-023 Valid draw: SHALL latch i0, i1, and value v=lfsr[GENE_W+23:24] (GENE_W>8 zero-extends), then go to APPLY.
REQ-024 Invalid draw with retry<MAX_RETRY: SHALL step lfsr, increment retry, and stay in DRAW.
REQ-025 Invalid draw with retry==MAX_RETRY: SHALL increment skipped, then treat the operation as finished under REQ-027.
REQ-026 APPLY mode 0 SHALL exchange genes i0 and i1 in one cycle; mode 1 SHALL write v into gene i0; all other genes unchanged.
REQ-027 On operation finish: SHALL decrement ops_left, clear retry, and step lfsr; if ops_left was 1, go to DONE, else to DRAW.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE; mutant SHALL hold its value in IDLE until the next accepted start.
REQ-029 Mode 0 SHALL preserve the multiset of genes (permutation only).
REQ-030 GENE_N==1 in mode 0 SHALL never yield a valid draw, so every operation is skipped and mutant==parent.
REQ-031 Latency start-to-done with zero rejections SHALL be 3 + 2*ops cycles after the accepting edge; each rejection adds 1 cycle.

Reset
REQ-032 rst=1 on an edge SHALL force state=IDLE, mutant=0, lfsr=32'h1, ops_left=0, retry=0, skipped=0; busy=0, done=0.
REQ-033 rst SHALL take priority over start and over any in-progress state; a run interrupted by reset is abandoned with no done pulse.

Verification
REQ-034 Assert rst for 2 cycles with start=1 -> mutant=0, busy=0, done=0, skipped=0; no run starts.
REQ-035 Defaults, mode 0, parent genes 0..14, seed 32'hDEADBEEF -> done pulses once; mutant is a permutation of 0..14; start-to-done cycles match REQ-031 as computed by the reference LFSR model.
REQ-036 GENE_N=1, mode 0, parent=5'h1B, any seed -> mutant==5'h1B; skipped==ops_left loaded in COUNT; every operation takes MAX_RETRY+1 DRAW cycles.
REQ-037 seed=0 vs seed=1, identical parent and mode -> bit-identical mutant and identical latency.
REQ-038 Pulse start again at cycle 2 of a run, then assert rst at cycle 4 -> the second start is ignored; after reset mutant=0, busy=0; no done pulse occurs.
REQ-039 Mode 1, defaults, parent all-zero -> at most ops genes differ from zero; done held exactly 1 cycle; mutant stable in IDLE for 10 cycles with start=0.
